// File: rtl/fifo_pkg.sv
// Package: fifo_pkg
// Shared helpers for the parametrised synchronous FIFO.
//   clog2         : constant ceil(log2) used to size addresses and pointers
//   DEFAULT_DEPTH : default entry count; DEFAULT_ADDR_W / DEFAULT_PTR_W
//                   give the matching address and pointer widths
//   *_MIN         : lower bounds used by the elaboration-time parameter checks
package fifo_pkg;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      res = res + 1;
    end
    return res;
  endfunction

  localparam int DEFAULT_DEPTH  = 16;
  localparam int DEFAULT_ADDR_W = clog2(DEFAULT_DEPTH);
  // The extra MSB is the wrap bit.
  localparam int DEFAULT_PTR_W  = DEFAULT_ADDR_W + 1;

  localparam int DEPTH_MIN     = 4;
  localparam int AF_THRESH_MIN = 1;
  localparam int AE_THRESH_MIN = 0;

endpackage

// File: rtl/fifo_sync_mem.sv
// Module: fifo_sync_mem
// DEPTH x DATA_W storage array for fifo_sync_param. Contents are never reset.
// Ports:
//   clk    in  clock, write on rising edge
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address (asynchronous read)
//   rdata  out read data, mem[raddr]
module fifo_sync_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Module: fifo_sync_param
// Single-clock parametrised FIFO with programmable almost-full/almost-empty
// flags, occupancy count and one-cycle overflow/underflow pulses.
// Build option: define FIFO_SYNC_FWFT_EN for first-word-fall-through output;
// otherwise dout is registered and loaded on each accepted read.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   wr_en, din              write request and data
//   full, almost_full       count == DEPTH, count >= AF_THRESH
//   rd_en                   read request (FWFT: pops the visible head word)
//   dout, valid             read data and its qualifier
//   empty, almost_empty     count == 0, count <= AE_THRESH
//   count                   occupancy 0..DEPTH
//   overflow, underflow     one-cycle pulse after a dropped write / read
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  localparam int AW = clog2(DEPTH),
  localparam int PW = AW + 1,
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              almost_full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              underflow
);

  if (DEPTH < DEPTH_MIN || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two >= %0d", DEPTH_MIN);
  end
  if (AF_THRESH < AF_THRESH_MIN || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_sync_param: AF_THRESH out of range");
  end
  if (AE_THRESH < AE_THRESH_MIN || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_param: AE_THRESH out of range");
  end

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d, almost_full_q, almost_full_d;
  logic              empty_q, empty_d, almost_empty_q, almost_empty_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] mem_rdata;

  // Accept decisions use the registered flags, i.e. the state before the edge.
  always_comb begin
    wr_acc         = wr_en & ~full_q;
    rd_acc         = rd_en & ~empty_q;
    wr_ptr_d       = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d       = rd_ptr_q + PW'(rd_acc);
    count_d        = count_q + CW'(wr_acc) - CW'(rd_acc);
    // Flags come from count_d so they track the post-edge occupancy exactly.
    full_d         = (count_d == CW'(DEPTH));
    almost_full_d  = (count_d >= CW'(AF_THRESH));
    empty_d        = (count_d == '0);
    almost_empty_d = (count_d <= CW'(AE_THRESH));
    overflow_d     = wr_en & full_q;
    underflow_d    = rd_en & empty_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      almost_full_q  <= almost_full_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  fifo_sync_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (din),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (mem_rdata)
  );

`ifdef FIFO_SYNC_FWFT_EN
  // Head word shown directly; forced to zero while empty so the output never
  // exposes stale or uninitialised memory (this also gives dout=0 in reset).
  assign dout  = empty_q ? '0 : mem_rdata;
  assign valid = ~empty_q;
`else
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;

  always_comb begin
    dout_d  = rd_acc ? mem_rdata : dout_q;
    valid_d = rd_acc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;
`endif

  assign full         = full_q;
  assign almost_full  = almost_full_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Testbench: tb_fifo_sync_param
// Directed phases plus random traffic against a queue-based reference model.
// Works for both output modes (FIFO_SYNC_FWFT_EN defined or not).
module tb_fifo_sync_param;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          full, almost_full, empty, almost_empty, valid, overflow, underflow;
  logic [DW-1:0] dout;
  logic [4:0]    count;

  fifo_sync_param #(
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .din          (din),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .dout         (dout),
    .valid        (valid),
    .empty        (empty),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

`ifdef FIFO_SYNC_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Reference model: queue of stored words plus registered-output expectations.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_dout  = '0;
  logic          exp_valid = 1'b0;
  logic          exp_ovf   = 1'b0;
  logic          exp_unf   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    int n;
    n = model_q.size();
    check({ph, ".count"},        32'(count),        32'(n));
    check({ph, ".full"},         32'(full),         32'(n == DEPTH));
    check({ph, ".almost_full"},  32'(almost_full),  32'(n >= AF));
    check({ph, ".empty"},        32'(empty),        32'(n == 0));
    check({ph, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
    check({ph, ".overflow"},     32'(overflow),     32'(exp_ovf));
    check({ph, ".underflow"},    32'(underflow),    32'(exp_unf));
    if (FWFT) begin
      check({ph, ".valid"}, 32'(valid), 32'(n > 0));
      check({ph, ".dout"},  dout,       (n > 0) ? model_q[0] : 32'h0);
    end else begin
      check({ph, ".valid"}, 32'(valid), 32'(exp_valid));
      check({ph, ".dout"},  dout,       exp_dout);
    end
  endtask

  // One clock transaction: drive, clock, update model, compare everything.
  task automatic step(input string ph, input logic wr, input logic [DW-1:0] d, input logic rd);
    int n;
    wr_en = wr;
    din   = d;
    rd_en = rd;
    @(posedge clk);
    #1;
    n         = model_q.size();
    exp_ovf   = wr && (n == DEPTH);
    exp_unf   = rd && (n == 0);
    exp_valid = 1'b0;
    if (rd && n > 0) begin
      exp_dout  = model_q.pop_front();
      exp_valid = 1'b1;
    end
    if (wr && n < DEPTH) model_q.push_back(d);
    $display("step %-10s wr=%0b din=%08h rd=%0b -> count=%0d dout=%08h valid=%0b ovf=%0b unf=%0b",
             ph, wr, d, rd, count, dout, valid, overflow, underflow);
    check_all(ph);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_all("in_reset");
    @(negedge clk);
    reset_n = 1'b1;

    // 1. idle after reset
    repeat (5) step("idle", 1'b0, '0, 1'b0);

    // 2. 17 back-to-back writes, last one dropped
    for (int i = 10; i <= 26; i++) step("fill", 1'b1, DW'(i), 1'b0);

    // 3. drain, then one extra read for underflow
    while (model_q.size() > 0) step("drain", 1'b0, '0, 1'b1);
    step("drain_unf", 1'b0, '0, 1'b1);
    step("post_unf", 1'b0, '0, 1'b0);

    // 4. thresholds: 13->14 and 14->13 for almost_full, 2->3 for almost_empty
    for (int i = 0; i < 14; i++) step("af_up", 1'b1, $urandom, 1'b0);
    step("af_down", 1'b0, '0, 1'b1);
    while (model_q.size() > 2) step("to_ae", 1'b0, '0, 1'b1);
    step("ae_up", 1'b1, $urandom, 1'b0);

    // 5. simultaneous read/write at mid, full and empty
    while (model_q.size() < 8) step("to8", 1'b1, $urandom, 1'b0);
    repeat (6) step("sim8", 1'b1, $urandom, 1'b1);
    while (model_q.size() < DEPTH) step("tofull", 1'b1, $urandom, 1'b0);
    step("simfull", 1'b1, $urandom, 1'b1);
    while (model_q.size() > 0) step("toempty", 1'b0, '0, 1'b1);
    step("simempty", 1'b1, $urandom, 1'b1);
    step("simempty2", 1'b0, '0, 1'b0);

    // random traffic, write-heavy then read-heavy
    for (int i = 0; i < 300; i++) begin
      step("rand",
           $urandom_range(0, 99) < ((i < 150) ? 70 : 30),
           $urandom,
           $urandom_range(0, 99) < ((i < 150) ? 40 : 75));
    end

    // 6. fill to 5, then asynchronous reset in the middle of a write
    while (model_q.size() > 0) step("pre_rst", 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) step("to5", 1'b1, $urandom, 1'b0);
    wr_en = 1'b1;
    din   = $urandom;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    repeat (2) @(posedge clk);
    #1 check_all("rst_hold");
    @(negedge clk);
    wr_en   = 1'b0;
    reset_n = 1'b1;
    step("post_rst_wr", 1'b1, 32'h0000_00A5, 1'b0);
    if (FWFT) check("a5_first_fwft", dout, 32'h0000_00A5);
    step("post_rst_rd", 1'b0, '0, 1'b1);
    if (!FWFT) check("a5_first_std", dout, 32'h0000_00A5);
    step("final_idle", 1'b0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
